// File: rtl/axi_read_intf_if.sv
// AXI4 read-address/read-data channels plus the internal storage read port.
// The slave modport is the design side; the master modport is the bus/storage side.
interface axi_read_intf_if #(
    parameter int ARID_WIDTH   = 8,
    parameter int ARADDR_WIDTH = 11,
    parameter int RDATA_WIDTH  = 32
);
    logic [ARID_WIDTH-1:0]   ARID;
    logic [ARADDR_WIDTH-1:0] ARADDR;
    logic [7:0]              ARLEN;
    logic [2:0]              ARSIZE;
    logic [1:0]              ARBURST;
    logic [3:0]              ARREGION;
    logic                    ARVALID;
    logic                    ARREADY;
    logic [ARID_WIDTH-1:0]   RID;
    logic [RDATA_WIDTH-1:0]  RDATA;
    logic [1:0]              RRESP;
    logic                    RLAST;
    logic                    RVALID;
    logic                    RREADY;
    logic                    axi_rd_req;
    logic [ARADDR_WIDTH-1:0] axi_rd_addr;
    logic [1:0]              axi_rd_region;
    logic                    rd_data_vld;
    logic [RDATA_WIDTH-1:0]  rd_data;
    logic                    rd_err;

    modport slave (
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARREGION, ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY,
        output axi_rd_req, axi_rd_addr, axi_rd_region,
        input  rd_data_vld, rd_data, rd_err
    );

    modport master (
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARREGION, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY,
        input  axi_rd_req, axi_rd_addr, axi_rd_region,
        output rd_data_vld, rd_data, rd_err
    );
endinterface

// File: rtl/axi_read_intf.sv
// AXI4 read slave: one burst at a time, one internal single-beat request per beat.
// Illegal bursts (size > 4 bytes or reserved burst type) return SLVERR beats with no access.
module axi_read_intf #(
    parameter int ARID_WIDTH   = 8,
    parameter int ARADDR_WIDTH = 11,
    parameter int RDATA_WIDTH  = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    axi_read_intf_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_SEND
    } state_t;

    state_t                  r_state;
    logic                    r_arready;
    logic [ARID_WIDTH-1:0]   r_id;
    logic [ARADDR_WIDTH-1:0] r_addr;
    logic [7:0]              r_cnt;
    logic [2:0]              r_size;
    logic [1:0]              r_burst;
    logic [1:0]              r_region;
    logic                    r_err;
    logic                    r_req;
    logic [RDATA_WIDTH-1:0]  r_rdata;
    logic [1:0]              r_rresp;
    logic                    r_rlast;
    logic                    r_rvalid;

    logic                    w_ar_hs;
    logic                    w_ar_bad;
    logic                    w_r_hs;
    logic [ARADDR_WIDTH-1:0] w_step;
    logic [ARADDR_WIDTH-1:0] w_next_addr;

    assign w_ar_hs  = bus.ARVALID & r_arready;
    assign w_ar_bad = (bus.ARSIZE > 3'd2) | (bus.ARBURST == 2'b11);
    assign w_r_hs   = r_rvalid & bus.RREADY;

    // WRAP advances like INCR; the adder wraps modulo the address width
    always_comb begin
        w_step = '0;
        unique case (r_size)
            3'd0:    w_step = ARADDR_WIDTH'(1);
            3'd1:    w_step = ARADDR_WIDTH'(2);
            default: w_step = ARADDR_WIDTH'(4);
        endcase
        w_next_addr = r_addr;
        if (r_burst != 2'b00)
            w_next_addr = r_addr + w_step;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_arready <= 1'b1;
            r_id      <= '0;
            r_addr    <= '0;
            r_cnt     <= '0;
            r_size    <= '0;
            r_burst   <= '0;
            r_region  <= '0;
            r_err     <= 1'b0;
            r_req     <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= 2'b00;
            r_rlast   <= 1'b0;
            r_rvalid  <= 1'b0;
        end else begin
            r_req <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_ar_hs) begin
                        r_arready <= 1'b0;
                        r_id      <= bus.ARID;
                        r_addr    <= bus.ARADDR;
                        r_cnt     <= bus.ARLEN;
                        r_size    <= bus.ARSIZE;
                        r_burst   <= bus.ARBURST;
                        r_region  <= bus.ARREGION[1:0];
                        r_err     <= w_ar_bad;
                        if (w_ar_bad) begin
                            r_rdata  <= '0;
                            r_rresp  <= 2'b10;
                            r_rlast  <= (bus.ARLEN == 8'd0);
                            r_rvalid <= 1'b1;
                            r_state  <= S_SEND;
                        end else begin
                            r_req    <= 1'b1;
                            r_state  <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.rd_data_vld) begin
                        r_rdata  <= bus.rd_data;
                        r_rresp  <= bus.rd_err ? 2'b10 : 2'b00;
                        r_rlast  <= (r_cnt == 8'd0);
                        r_rvalid <= 1'b1;
                        r_state  <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (w_r_hs) begin
                        if (r_rlast) begin
                            r_rvalid  <= 1'b0;
                            r_rlast   <= 1'b0;
                            r_arready <= 1'b1;
                            r_state   <= S_IDLE;
                        end else begin
                            r_cnt  <= r_cnt - 8'd1;
                            r_addr <= w_next_addr;
                            if (r_err) begin
                                r_rlast <= (r_cnt == 8'd1);
                            end else begin
                                r_rvalid <= 1'b0;
                                r_rlast  <= 1'b0;
                                r_req    <= 1'b1;
                                r_state  <= S_REQ;
                            end
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.ARREADY       = r_arready;
    assign bus.RID           = r_id;
    assign bus.RDATA         = r_rdata;
    assign bus.RRESP         = r_rresp;
    assign bus.RLAST         = r_rlast;
    assign bus.RVALID        = r_rvalid;
    assign bus.axi_rd_req    = r_req;
    assign bus.axi_rd_addr   = r_addr;
    assign bus.axi_rd_region = r_region;
endmodule

// File: tb/tb_axi_read_intf.sv
// Scoreboard bench for axi_read_intf: stimulus queues expected requests and
// beats, a negedge monitor pops and compares; a responder models storage.
module tb_axi_read_intf;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    axi_read_intf_if #(
        .ARID_WIDTH(8), .ARADDR_WIDTH(11), .RDATA_WIDTH(32)
    ) bus ();

    axi_read_intf #(
        .ARID_WIDTH(8), .ARADDR_WIDTH(11), .RDATA_WIDTH(32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [7:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } rbeat_t;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } rsp_t;

    rbeat_t      exp_r_q[$];
    logic [10:0] exp_a_q[$];
    rsp_t        rsp_q[$];

    int n_cmp   = 0;
    int n_bad   = 0;
    int req_cnt = 0;
    int rsp_lat = 1;

    rbeat_t hold_b;
    bit     hold_v = 1'b0;
    rsp_t   rsp_cur;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got event, want none (or timeout)", name);
    endtask

    // Monitor: requests and R beats popped against the scoreboard queues
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.axi_rd_req) begin
                req_cnt++;
                if (exp_a_q.size() == 0)
                    fail("unexpected_req");
                else
                    chk("rd_addr", 64'(bus.axi_rd_addr), 64'(exp_a_q.pop_front()));
            end
            if (hold_v)
                chk("r_stable",
                    {bus.RVALID, bus.RID, bus.RDATA, bus.RRESP, bus.RLAST},
                    {1'b1, hold_b});
            hold_v = bus.RVALID && !bus.RREADY;
            hold_b = {bus.RID, bus.RDATA, bus.RRESP, bus.RLAST};
            if (bus.RVALID && bus.RREADY) begin
                if (exp_r_q.size() == 0)
                    fail("unexpected_beat");
                else
                    chk("r_beat",
                        64'({bus.RID, bus.RDATA, bus.RRESP, bus.RLAST}),
                        64'(exp_r_q.pop_front()));
            end
        end else begin
            hold_v = 1'b0;
        end
    end

    // Storage model: answers each request after rsp_lat cycles
    initial begin
        bus.rd_data_vld = 1'b0;
        bus.rd_data     = '0;
        bus.rd_err      = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.axi_rd_req) begin
                if (rsp_q.size() != 0)
                    rsp_cur = rsp_q.pop_front();
                else
                    rsp_cur = '{data: 32'hA500_0000 | 32'(bus.axi_rd_addr),
                                err: 1'b0};
                repeat (rsp_lat) @(posedge clk);
                #1;
                bus.rd_data_vld = 1'b1;
                bus.rd_data     = rsp_cur.data;
                bus.rd_err      = rsp_cur.err;
                @(posedge clk);
                #1;
                bus.rd_data_vld = 1'b0;
                bus.rd_err      = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    task automatic send_ar(input logic [7:0] id, input logic [10:0] addr,
                           input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] region);
        int t = 0;
        while (!bus.ARREADY && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (!bus.ARREADY) fail("ar_wait");
        bus.ARID     = id;
        bus.ARADDR   = addr;
        bus.ARLEN    = len;
        bus.ARSIZE   = size;
        bus.ARBURST  = burst;
        bus.ARREGION = region;
        bus.ARVALID  = 1'b1;
        @(posedge clk); #1;
        bus.ARVALID  = 1'b0;
        chk("arready_busy", 64'(bus.ARREADY), 64'(0));
        chk("rd_region", 64'(bus.axi_rd_region), 64'(region[1:0]));
    endtask

    task automatic drain(input string name);
        int t = 0;
        while (exp_r_q.size() != 0 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (exp_r_q.size() != 0) begin
            fail({name, "_timeout"});
            exp_r_q.delete();
        end
        @(posedge clk); #1;
        chk({name, "_arready"}, 64'(bus.ARREADY), 64'(1));
        chk({name, "_rvalid"}, 64'(bus.RVALID), 64'(0));
        chk({name, "_addrq"}, 64'(exp_a_q.size()), 64'(0));
        exp_a_q.delete();
    endtask

    task automatic chk_reset(input string name);
        chk({name, "_arready"}, 64'(bus.ARREADY), 64'(1));
        chk({name, "_rvalid"}, 64'(bus.RVALID), 64'(0));
        chk({name, "_rlast"}, 64'(bus.RLAST), 64'(0));
        chk({name, "_rresp"}, 64'(bus.RRESP), 64'(0));
        chk({name, "_rid"}, 64'(bus.RID), 64'(0));
        chk({name, "_rdata"}, 64'(bus.RDATA), 64'(0));
        chk({name, "_req"}, 64'(bus.axi_rd_req), 64'(0));
        chk({name, "_addr"}, 64'(bus.axi_rd_addr), 64'(0));
        chk({name, "_region"}, 64'(bus.axi_rd_region), 64'(0));
    endtask

    initial begin
        int r0;
        int t;
        bus.ARID = '0; bus.ARADDR = '0; bus.ARLEN = '0;
        bus.ARSIZE = '0; bus.ARBURST = '0; bus.ARREGION = '0;
        bus.ARVALID = 1'b0;
        bus.RREADY  = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk_reset("rst_hold");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset("rst_idle");

        // single beat, response latency 2
        rsp_lat = 2;
        r0 = req_cnt;
        rsp_q.push_back('{data: 32'hDEADBEEF, err: 1'b0});
        exp_a_q.push_back(11'h010);
        exp_r_q.push_back('{id: 8'h5A, data: 32'hDEADBEEF, resp: 2'b00, last: 1'b1});
        send_ar(8'h5A, 11'h010, 8'd0, 3'd2, 2'b01, 4'h1);
        drain("single");
        chk("single_reqs", 64'(req_cnt - r0), 64'(1));
        rsp_lat = 1;

        // INCR burst of 4
        r0 = req_cnt;
        exp_a_q.push_back(11'h100); exp_a_q.push_back(11'h104);
        exp_a_q.push_back(11'h108); exp_a_q.push_back(11'h10C);
        exp_r_q.push_back('{8'h21, 32'hA500_0100, 2'b00, 1'b0});
        exp_r_q.push_back('{8'h21, 32'hA500_0104, 2'b00, 1'b0});
        exp_r_q.push_back('{8'h21, 32'hA500_0108, 2'b00, 1'b0});
        exp_r_q.push_back('{8'h21, 32'hA500_010C, 2'b00, 1'b1});
        send_ar(8'h21, 11'h100, 8'd3, 3'd2, 2'b01, 4'hE);
        drain("incr");
        chk("incr_reqs", 64'(req_cnt - r0), 64'(4));

        // FIXED burst of 4, byte size 1 on an odd address via WRAP is later
        r0 = req_cnt;
        for (int i = 0; i < 4; i++) begin
            exp_a_q.push_back(11'h100);
            exp_r_q.push_back('{8'h22, 32'hA500_0100, 2'b00, 1'(i == 3)});
        end
        send_ar(8'h22, 11'h100, 8'd3, 3'd2, 2'b00, 4'h2);
        drain("fixed");
        chk("fixed_reqs", 64'(req_cnt - r0), 64'(4));

        // WRAP with halfword size advances like INCR by 2
        exp_a_q.push_back(11'h041); exp_a_q.push_back(11'h043);
        exp_r_q.push_back('{8'h23, 32'hA500_0041, 2'b00, 1'b0});
        exp_r_q.push_back('{8'h23, 32'hA500_0043, 2'b00, 1'b1});
        send_ar(8'h23, 11'h041, 8'd1, 3'd1, 2'b10, 4'h3);
        drain("wrap");

        // backpressure on beat 1 with a per-beat error
        r0 = req_cnt;
        bus.RREADY = 1'b0;
        rsp_q.push_back('{data: 32'h1234_5678, err: 1'b1});
        rsp_q.push_back('{data: 32'h9ABC_DEF0, err: 1'b0});
        exp_a_q.push_back(11'h200); exp_a_q.push_back(11'h204);
        exp_r_q.push_back('{8'h3C, 32'h1234_5678, 2'b10, 1'b0});
        exp_r_q.push_back('{8'h3C, 32'h9ABC_DEF0, 2'b00, 1'b1});
        send_ar(8'h3C, 11'h200, 8'd1, 3'd2, 2'b01, 4'h0);
        t = 0;
        while (!bus.RVALID && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (!bus.RVALID) fail("bp_rvalid_wait");
        repeat (5) @(posedge clk);
        #1;
        chk("bp_held_resp", 64'(bus.RRESP), 64'(2));
        chk("bp_held_data", 64'(bus.RDATA), 64'(32'h1234_5678));
        bus.RREADY = 1'b1;
        drain("bp");
        chk("bp_reqs", 64'(req_cnt - r0), 64'(2));

        // illegal size: SLVERR beats, no internal access
        r0 = req_cnt;
        for (int i = 0; i < 3; i++)
            exp_r_q.push_back('{8'h44, 32'h0, 2'b10, 1'(i == 2)});
        send_ar(8'h44, 11'h300, 8'd2, 3'd3, 2'b01, 4'h1);
        drain("bad_size");
        chk("bad_size_reqs", 64'(req_cnt - r0), 64'(0));

        // reserved burst type
        r0 = req_cnt;
        for (int i = 0; i < 3; i++)
            exp_r_q.push_back('{8'h45, 32'h0, 2'b10, 1'(i == 2)});
        send_ar(8'h45, 11'h300, 8'd2, 3'd2, 2'b11, 4'h1);
        drain("bad_burst");
        chk("bad_burst_reqs", 64'(req_cnt - r0), 64'(0));

        // 256-beat burst wrapping past the top of the address space
        r0 = req_cnt;
        for (int i = 0; i < 256; i++) begin
            logic [10:0] a;
            a = 11'h7FC + 11'(4 * i);
            exp_a_q.push_back(a);
            exp_r_q.push_back('{8'h77, 32'hA500_0000 | 32'(a), 2'b00,
                                1'(i == 255)});
        end
        send_ar(8'h77, 11'h7FC, 8'd255, 3'd2, 2'b01, 4'h2);
        drain("long");
        chk("long_reqs", 64'(req_cnt - r0), 64'(256));

        // reset while waiting on beat 2; the late response must be ignored
        rsp_lat = 8;
        exp_a_q.push_back(11'h300); exp_a_q.push_back(11'h304);
        exp_r_q.push_back('{8'h33, 32'hA500_0300, 2'b00, 1'b0});
        send_ar(8'h33, 11'h300, 8'd2, 3'd2, 2'b01, 4'h2);
        t = 0;
        while (exp_r_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (exp_r_q.size() != 0) fail("rst_beat1_wait");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset("rst_mid");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk_reset("rst_after");
        chk("rst_addrq", 64'(exp_a_q.size()), 64'(0));
        exp_a_q.delete();
        exp_r_q.delete();
        rsp_lat = 1;

        // recovery after reset
        exp_a_q.push_back(11'h0F0);
        exp_r_q.push_back('{8'h99, 32'hA500_00F0, 2'b00, 1'b1});
        send_ar(8'h99, 11'h0F0, 8'd0, 3'd0, 2'b01, 4'h3);
        drain("recover");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
